// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared rv32i core widths, fetch-stage types and reset constants
package rv32i_pkg;
    localparam int XLEN = 32;
    localparam int INSTR_WIDTH = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    typedef enum logic [1:0] {FETCH_IDLE, FETCH_RUN, FETCH_FAULT} fetch_state_t;
    typedef struct packed {
        logic [XLEN-1:0]        pc;
        logic [INSTR_WIDTH-1:0] instr;
    } fetch_pkt_t;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: imem request/response, redirect and decode handshake bundle of the fetch stage
interface fetch_unit_if;
    logic                                imem_req_valid;
    logic                                imem_req_ready;
    logic [rv32i_pkg::XLEN-1:0]          imem_req_addr;
    logic                                imem_rsp_valid;
    logic [rv32i_pkg::INSTR_WIDTH-1:0]   imem_rsp_data;
    logic                                redirect_valid;
    logic [rv32i_pkg::XLEN-1:0]          redirect_pc;
    logic                                id_valid;
    logic                                id_ready;
    logic [rv32i_pkg::INSTR_WIDTH-1:0]   id_instr;
    logic [rv32i_pkg::XLEN-1:0]          id_pc;
    logic                                fetch_fault;
    modport master (
        output imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, fetch_fault,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, id_ready
    );
    modport slave (
        input  imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, fetch_fault,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/fetch_buf.sv
// fetch_buf: circular FIFO of fetch packets with synchronous flush
module fetch_buf import rv32i_pkg::*; #(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       areset_n,
    input  logic       flush,
    input  logic       push,
    input  logic       pop,
    input  fetch_pkt_t din,
    output fetch_pkt_t dout,
    output logic [AW:0] count,
    output logic       full,
    output logic       empty
);
    fetch_pkt_t mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    assign dout  = mem[rd_ptr];
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    // Entries are reset so the decode-facing head reads zero out of reset.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: rv32i fetch stage - PC, credit-limited imem requests, in-order response buffer, redirects
module fetch_unit import rv32i_pkg::*; #(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int              BUF_DEPTH = 2
) (
    input  logic clk,
    input  logic areset_n,
    fetch_unit_if.master bus
);
    localparam int CW = $clog2(BUF_DEPTH) + 1;
    fetch_state_t    state, state_nx;
    logic [XLEN-1:0] pc, rsp_pc, target;
    logic [CW-1:0]   inflight, discard, count;
    logic            req_fire, push, pop, misaligned, full, empty;
    fetch_pkt_t      pkt, head;
    assign target     = {bus.redirect_pc[XLEN-1:2], 2'b00};
    assign misaligned = bus.redirect_pc[1:0] != 2'b00;
    // Outstanding requests plus buffered entries never exceed the buffer, so pushes cannot overflow.
    assign bus.imem_req_valid = state == FETCH_RUN && !bus.redirect_valid && (inflight + count) < CW'(BUF_DEPTH);
    assign bus.imem_req_addr  = pc;
    assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
    assign push     = bus.imem_rsp_valid && !bus.redirect_valid && discard == '0 && !full;
    assign pop      = bus.id_valid && bus.id_ready;
    assign pkt      = '{pc: rsp_pc, instr: bus.imem_rsp_data};
    assign bus.id_valid    = !empty;
    assign bus.id_pc       = head.pc;
    assign bus.id_instr    = head.instr;
    assign bus.fetch_fault = state == FETCH_FAULT;
    always_comb begin
        state_nx = state;
        state_nx = state == FETCH_IDLE ? FETCH_RUN :
                   bus.redirect_valid  ? (misaligned ? FETCH_FAULT : FETCH_RUN) : state;
    end
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state    <= FETCH_IDLE;
            pc       <= RESET_PC;
            rsp_pc   <= RESET_PC;
            inflight <= '0;
            discard  <= '0;
        end else begin
            state    <= state_nx;
            inflight <= inflight + CW'(req_fire) - CW'(bus.imem_rsp_valid);
            if (bus.redirect_valid) begin
                pc      <= target;
                rsp_pc  <= target;
                discard <= inflight - CW'(bus.imem_rsp_valid);
            end else begin
                if (req_fire) pc <= pc + XLEN'(4);
                if (push) rsp_pc <= rsp_pc + XLEN'(4);
                if (bus.imem_rsp_valid && discard != '0) discard <= discard - 1'b1;
            end
        end
    end
    fetch_buf #(.DEPTH(BUF_DEPTH)) u_buf (
        .clk      (clk),
        .areset_n (areset_n),
        .flush    (bus.redirect_valid),
        .push     (push),
        .pop      (pop),
        .din      (pkt),
        .dout     (head),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized self-checking bench for fetch_unit against a stream-level model
module tb_fetch_unit;
    import rv32i_pkg::*;
    localparam int DEPTH = 2;
    logic clk = 0;
    logic areset_n = 0;
    int total = 0;
    int bad = 0;
    int lat = 1;
    int cyc = 0;
    int n_req = 0;
    int held = 0;
    int stale = 0;
    int last_due = 0;
    logic fault_m = 0;
    logic [31:0] exp_pc = 0;
    logic [31:0] exp_req = 0;
    logic [31:0] q_addr[$];
    int q_due[$];
    logic [31:0] hs_log[$];

    fetch_unit_if bus();
    fetch_unit #(.RESET_PC(32'h0), .BUF_DEPTH(DEPTH)) dut (.clk(clk), .areset_n(areset_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h0000_0013;
    endfunction

    // memory: in-order responses, each presented lat cycles after its request is accepted
    initial begin
        bus.imem_rsp_valid = 0;
        bus.imem_rsp_data = 0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (q_due.size() != 0 && q_due[0] <= cyc) begin
                bus.imem_rsp_valid = 1;
                bus.imem_rsp_data = word(q_addr[0]);
                q_due.delete(0);
                q_addr.delete(0);
            end else begin
                bus.imem_rsp_valid = 0;
                bus.imem_rsp_data = 32'hDEAD_BEEF;
            end
        end
    end

    // stream model: decode must see target, target+4, ... with matching words; stale responses never show
    initial forever begin
        @(negedge clk);
        if (!areset_n) begin
            q_addr.delete(); q_due.delete();
            held = 0; stale = 0; last_due = 0; fault_m = 0; exp_pc = 0; exp_req = 0;
        end else begin
            total++;
            if (bus.id_valid !== (held != 0)) begin bad++; $display("FAIL id_valid: got %b want %b", bus.id_valid, held != 0); end
            total++;
            if (bus.fetch_fault !== fault_m) begin bad++; $display("FAIL fetch_fault: got %b want %b", bus.fetch_fault, fault_m); end
            if (bus.id_valid && bus.id_ready) begin
                total++;
                if (bus.id_pc !== exp_pc || bus.id_instr !== word(exp_pc))
                    begin bad++; $display("FAIL id_pkt: got pc=%h instr=%h want pc=%h instr=%h", bus.id_pc, bus.id_instr, exp_pc, word(exp_pc)); end
                hs_log.push_back(bus.id_pc);
                held--;
                exp_pc = exp_pc + 32'd4;
            end
            if (bus.imem_rsp_valid && !bus.redirect_valid) begin
                if (stale > 0) stale--; else held++;
            end
            if (bus.redirect_valid) begin
                total++;
                if (bus.imem_req_valid !== 1'b0) begin bad++; $display("FAIL req_in_redirect: got %b want 0", bus.imem_req_valid); end
                held = 0;
                stale = q_due.size();
                exp_pc = {bus.redirect_pc[31:2], 2'b00};
                exp_req = exp_pc;
                fault_m = bus.redirect_pc[1:0] != 2'b00;
            end
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                total++;
                if (bus.imem_req_addr !== exp_req || fault_m)
                    begin bad++; $display("FAIL req_addr: got %h (fault=%b) want %h", bus.imem_req_addr, fault_m, exp_req); end
                exp_req = exp_req + 32'd4;
                n_req++;
                last_due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
                q_addr.push_back(bus.imem_req_addr);
                q_due.push_back(last_due);
            end
            total++;
            if (held + q_due.size() > DEPTH) begin bad++; $display("FAIL credit: got %0d want <=%0d", held + q_due.size(), DEPTH); end
        end
    end

    task automatic do_reset(input logic rdy);
        @(posedge clk); #3 areset_n = 0;
        bus.redirect_valid = 0;
        bus.id_ready = rdy;
        n_req = 0;
        repeat (2) @(posedge clk);
        #3 areset_n = 1;
    endtask

    task automatic redirect(input logic [31:0] target);
        @(posedge clk); #1;
        bus.redirect_valid = 1;
        bus.redirect_pc = target;
        @(posedge clk); #1;
        bus.redirect_valid = 0;
    endtask

    task automatic wait_hs(input int need, input string name);
        for (int i = 0; i < 80 && hs_log.size() < need; i++) begin @(posedge clk); #1; end
        total++;
        if (hs_log.size() < need) begin bad++; $display("FAIL %s_timeout: got %0d handshakes want %0d", name, hs_log.size(), need); end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        total++;
        if ({bus.imem_req_valid, bus.id_valid, bus.fetch_fault} !== 3'b000)
            begin bad++; $display("FAIL reset_flags: got %b want 000", {bus.imem_req_valid, bus.id_valid, bus.fetch_fault}); end
        total++;
        if (bus.imem_req_addr !== 32'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", bus.imem_req_addr); end
        total++;
        if (bus.id_instr !== 32'h0 || bus.id_pc !== 32'h0) begin bad++; $display("FAIL reset_id: got %h/%h want 0/0", bus.id_pc, bus.id_instr); end
        @(posedge clk); #3 areset_n = 1;
        #1;
        total++;
        if (bus.imem_req_valid !== 1'b0) begin bad++; $display("FAIL req_cycle1: got %b want 0", bus.imem_req_valid); end
        @(posedge clk); #1;
        total++;
        if (bus.imem_req_valid !== 1'b1) begin bad++; $display("FAIL req_cycle2: got %b want 1", bus.imem_req_valid); end
        @(posedge clk); #1;
        total++;
        if (bus.id_valid !== 1'b0) begin bad++; $display("FAIL id_early: got %b want 0", bus.id_valid); end
        @(posedge clk); #1;
        total++;
        if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h0 || bus.id_instr !== 32'h13)
            begin bad++; $display("FAIL id_first: got v=%b pc=%h instr=%h want 1/0/13", bus.id_valid, bus.id_pc, bus.id_instr); end
    endtask

    task automatic test_stream;
        repeat (30) @(posedge clk);
        #1;
        total++;
        if (hs_log.size() < 15) begin bad++; $display("FAIL stream_rate: got %0d want >=15", hs_log.size()); end
        for (int i = 0; i < hs_log.size(); i++) begin
            total++;
            if (hs_log[i] !== 32'(i * 4)) begin bad++; $display("FAIL stream_pc[%0d]: got %h want %h", i, hs_log[i], 32'(i * 4)); end
        end
    endtask

    task automatic test_backpressure;
        int base;
        do_reset(1'b0);
        repeat (12) @(posedge clk);
        #1;
        total++;
        if (n_req != DEPTH) begin bad++; $display("FAIL bp_requests: got %0d want %0d", n_req, DEPTH); end
        total++;
        if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h0) begin bad++; $display("FAIL bp_head: got v=%b pc=%h want 1/0", bus.id_valid, bus.id_pc); end
        base = hs_log.size();
        bus.id_ready = 1;
        wait_hs(base + 3, "bp");
        for (int i = 0; i < 3 && base + i < hs_log.size(); i++) begin
            total++;
            if (hs_log[base + i] !== 32'(i * 4)) begin bad++; $display("FAIL bp_order[%0d]: got %h want %h", i, hs_log[base + i], 32'(i * 4)); end
        end
    endtask

    task automatic test_redirect;
        int base;
        bit found = 0;
        lat = 3;
        for (int i = 0; i < 50 && !found; i++) begin
            @(posedge clk); #2;
            found = q_due.size() == 2 && !bus.imem_rsp_valid;
        end
        total++;
        if (!found) begin bad++; $display("FAIL redir_setup: got no cycle with 2 outstanding want one"); end
        bus.redirect_valid = 1;
        bus.redirect_pc = 32'h100;
        @(posedge clk); #1;
        bus.redirect_valid = 0;
        base = hs_log.size();
        total++;
        if (bus.imem_req_addr !== 32'h100) begin bad++; $display("FAIL redir_addr: got %h want 100", bus.imem_req_addr); end
        wait_hs(base + 1, "redir");
        total++;
        if (hs_log.size() > base && hs_log[base] !== 32'h100) begin bad++; $display("FAIL redir_pc: got %h want 100", hs_log[base]); end
    endtask

    task automatic test_misaligned;
        int n0, base;
        lat = 1;
        redirect(32'h102);
        n0 = n_req;
        total++;
        if (bus.fetch_fault !== 1'b1 || bus.imem_req_valid !== 1'b0)
            begin bad++; $display("FAIL fault_enter: got fault=%b req=%b want 1/0", bus.fetch_fault, bus.imem_req_valid); end
        repeat (8) @(posedge clk);
        #1;
        total++;
        if (n_req != n0 || bus.fetch_fault !== 1'b1 || bus.id_valid !== 1'b0)
            begin bad++; $display("FAIL fault_hold: got reqs=%0d fault=%b idv=%b want 0/1/0", n_req - n0, bus.fetch_fault, bus.id_valid); end
        redirect(32'h200);
        base = hs_log.size();
        total++;
        if (bus.fetch_fault !== 1'b0 || bus.imem_req_addr !== 32'h200)
            begin bad++; $display("FAIL fault_exit: got fault=%b addr=%h want 0/200", bus.fetch_fault, bus.imem_req_addr); end
        wait_hs(base + 1, "resume");
        total++;
        if (hs_log.size() > base && hs_log[base] !== 32'h200) begin bad++; $display("FAIL resume_pc: got %h want 200", hs_log[base]); end
    endtask

    task automatic test_wrap;
        int base;
        logic [31:0] want [3] = '{32'hFFFF_FFFC, 32'h0, 32'h4};
        redirect(32'hFFFF_FFFC);
        base = hs_log.size();
        wait_hs(base + 3, "wrap");
        for (int i = 0; i < 3 && base + i < hs_log.size(); i++) begin
            total++;
            if (hs_log[base + i] !== want[i]) begin bad++; $display("FAIL wrap[%0d]: got %h want %h", i, hs_log[base + i], want[i]); end
        end
    endtask

    task automatic test_async_reset;
        int base;
        bus.id_ready = 0;
        repeat (10) @(posedge clk);
        #3 areset_n = 0;
        #1;
        total++;
        if (bus.id_valid !== 1'b0 || bus.imem_req_valid !== 1'b0)
            begin bad++; $display("FAIL async_reset: got idv=%b req=%b want 0/0", bus.id_valid, bus.imem_req_valid); end
        base = hs_log.size();
        bus.id_ready = 1;
        repeat (2) @(posedge clk);
        #3 areset_n = 1;
        wait_hs(base + 3, "restart");
        for (int i = 0; i < 3 && base + i < hs_log.size(); i++) begin
            total++;
            if (hs_log[base + i] !== 32'(i * 4)) begin bad++; $display("FAIL restart[%0d]: got %h want %h", i, hs_log[base + i], 32'(i * 4)); end
        end
    endtask

    task automatic test_random;
        logic [31:0] r;
        int base = hs_log.size();
        repeat (400) begin
            @(posedge clk); #1;
            bus.id_ready = $urandom_range(0, 3) != 0;
            bus.imem_req_ready = $urandom_range(0, 3) != 0;
            lat = $urandom_range(1, 4);
            r = $urandom;
            bus.redirect_valid = $urandom_range(0, 19) == 0;
            bus.redirect_pc = ($urandom_range(0, 7) == 0) ? r : (r & ~32'h3);
        end
        bus.id_ready = 1;
        bus.imem_req_ready = 1;
        redirect(32'h40);
        repeat (10) @(posedge clk);
        #1;
        total++;
        if (bus.fetch_fault !== 1'b0) begin bad++; $display("FAIL rand_recover: got %b want 0", bus.fetch_fault); end
        total++;
        if (hs_log.size() - base < 20) begin bad++; $display("FAIL rand_progress: got %0d want >=20", hs_log.size() - base); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.imem_req_ready = 1;
        bus.redirect_valid = 0;
        bus.redirect_pc = 0;
        bus.id_ready = 1;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_misaligned();
        test_wrap();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
